// File: rtl/block_plotter.sv
// block_plotter
//   Responder side of the draw-control interface. Latches x / y / colour from
//   the shared switch inputs, sweeps a 4x4 pixel block while plot is held, and
//   can sweep the whole screen with colour 0 on a one-cycle clear request.
//
// Ports
//   clk, resetn    clock (rising edge) and asynchronous active-low reset
//   ld_x, ld_y     load x_reg / y_reg from data_in
//   ld_colour      load c_reg from colour_in
//   plot           burst enable, held for the 16 cycles of a block
//   data_in        shared x/y source
//   colour_in      colour source
//   clear          one-cycle request to clear the whole screen
//   counter_out    index of the block pixel issued this cycle
//   vga_x/y/colour pixel address and colour to the VGA adapter (registered)
//   vga_plot       write enable to the VGA adapter (registered)
//   busy           high while the clear sweep runs; this is also the visible
//                  view of the FSM state (busy == state is CLEAR)
//
// Handshake: there is no back-pressure. Every cycle that vga_plot is high the
// adapter takes (vga_x, vga_y, vga_colour); the caller observes burst progress
// through counter_out and clear progress through busy.
module block_plotter #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int C_W      = 3
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           ld_x,
  input  logic           ld_y,
  input  logic           ld_colour,
  input  logic           plot,
  input  logic [6:0]     data_in,
  input  logic [C_W-1:0] colour_in,
  input  logic           clear,
  output logic [3:0]     counter_out,
  output logic [7:0]     vga_x,
  output logic [6:0]     vga_y,
  output logic [C_W-1:0] vga_colour,
  output logic           vga_plot,
  output logic           busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [7:0] X_LIM  = 8'(SCREEN_W);
  localparam logic [7:0] Y_LIM  = 8'(SCREEN_H);
  localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
  localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);

  state_t         state;
  logic [7:0]     x_reg;
  logic [6:0]     y_reg;
  logic [C_W-1:0] c_reg;
  logic [3:0]     counter;
  logic [7:0]     cx;
  logic [6:0]     cy;

  // Block pixel address. Both sums are 8 bits so an anchor near the edge
  // produces an off-screen address that is clipped rather than wrapping back
  // onto the visible area.
  logic [7:0] x_sum;
  logic [7:0] y_sum;
  logic       on_screen;

  always_comb begin
    x_sum     = x_reg + {6'd0, counter[1:0]};
    y_sum     = {1'b0, y_reg} + {6'd0, counter[3:2]};
    on_screen = (x_sum < X_LIM) && (y_sum < Y_LIM);
  end

  assign counter_out = counter;

  // Operand registers load in any state, including during a clear sweep.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_reg <= '0;
      y_reg <= '0;
      c_reg <= '0;
    end else begin
      if (ld_x)      x_reg <= {1'b0, data_in};
      if (ld_y)      y_reg <= data_in;
      if (ld_colour) c_reg <= colour_in;
    end
  end

  // Control FSM with registered pixel outputs (one cycle behind the counter
  // or sweep position that produced them).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      counter    <= '0;
      cx         <= '0;
      cy         <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clear) begin
            // Clear wins over a simultaneous plot: no block pixel this cycle.
            state    <= CLEAR;
            busy     <= 1'b1;
            cx       <= '0;
            cy       <= '0;
            counter  <= '0;
            vga_plot <= 1'b0;
          end else if (plot) begin
            counter  <= counter + 4'd1;
            vga_plot <= on_screen;
            // A clipped pixel leaves the last written address/colour in place.
            if (on_screen) begin
              vga_x      <= x_sum;
              vga_y      <= y_sum[6:0];
              vga_colour <= c_reg;
            end
          end else begin
            counter  <= '0;
            vga_plot <= 1'b0;
          end
        end

        CLEAR: begin
          counter    <= '0;
          vga_x      <= cx;
          vga_y      <= cy;
          vga_colour <= '0;
          vga_plot   <= 1'b1;
          if (cx == X_LAST) begin
            cx <= '0;
            if (cy == Y_LAST) begin
              // Final pixel issued this cycle; busy drops alongside it.
              state <= IDLE;
              busy  <= 1'b0;
              cy    <= '0;
            end else begin
              cy <= cy + 7'd1;
            end
          end else begin
            cx <= cx + 8'd1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block_plotter.sv
module tb_block_plotter;

  localparam int SW = 160;
  localparam int SH = 120;

  // Clock / reset
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  always #5 clk = ~clk;

  logic       ld_x = 1'b0;
  logic       ld_y = 1'b0;
  logic       ld_colour = 1'b0;
  logic       plot = 1'b0;
  logic [6:0] data_in = '0;
  logic [2:0] colour_in = '0;
  logic       clear = 1'b0;
  logic [3:0] counter_out;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;

  block_plotter #(.SCREEN_W(SW), .SCREEN_H(SH), .C_W(3)) dut (
    .clk(clk), .resetn(resetn), .ld_x(ld_x), .ld_y(ld_y),
    .ld_colour(ld_colour), .plot(plot), .data_in(data_in),
    .colour_in(colour_in), .clear(clear), .counter_out(counter_out),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .busy(busy)
  );

  // Scoreboard: expected pixel writes in issue order, {x, y, colour}
  int checks = 0;
  int failures = 0;
  logic [17:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Every write seen by the adapter must be the next expected pixel.
  always @(negedge clk) begin
    if (resetn === 1'b1 && vga_plot === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=(%0d,%0d,%0d) required=no_write",
                 vga_x, vga_y, vga_colour);
      end else begin
        logic [17:0] got;
        got = exp_q.pop_front();
        check("pixel", {14'd0, vga_x, vga_y, vga_colour}, {14'd0, got});
      end
    end
  end

  // Model: a 4x4 block is every (x+i, y+j) i,j in 0..3, row by row, with
  // anything off the visible screen dropped.
  task automatic push_block(input int x, input int y, input int c);
    for (int k = 0; k < 16; k++) begin
      int px, py;
      px = x + (k % 4);
      py = y + (k / 4);
      if (px < SW && py < SH) exp_q.push_back({8'(px), 7'(py), 3'(c)});
    end
  endtask

  task automatic push_clear();
    for (int yy = 0; yy < SH; yy++)
      for (int xx = 0; xx < SW; xx++)
        exp_q.push_back({8'(xx), 7'(yy), 3'd0});
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_xyc(input int x, input int y, input int c, input bit lx);
    if (lx) begin
      tick();
      ld_x = 1'b1;
      data_in = 7'(x);
    end
    tick();
    ld_x = 1'b0;
    ld_y = 1'b1;
    ld_colour = 1'b1;
    data_in = 7'(y);
    colour_in = 3'(c);
    tick();
    ld_y = 1'b0;
    ld_colour = 1'b0;
  endtask

  task automatic abort_reset(input string tag);
    #2 resetn = 1'b0;
    #1;
    check({tag, "_outputs_zero"},
          {8'd0, counter_out, vga_x, vga_y, vga_colour, vga_plot, busy}, 32'd0);
    exp_q.delete();
    plot = 1'b0;
    clear = 1'b0;
    ld_x = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    check({tag, "_idle_after"}, {26'd0, busy, counter_out, vga_plot}, 32'd0);
  endtask

  // Expected writes must already be queued. abort_at<0 runs the full burst.
  task automatic run_burst(input int abort_at);
    plot = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("burst_counter", {28'd0, counter_out}, k);
      if (k == abort_at) begin
        abort_reset("burst_abort");
        return;
      end
    end
    tick();
    plot = 1'b0;
    @(negedge clk);
    check("counter_after_burst", {28'd0, counter_out}, 0);
    repeat (3) tick();
    check("burst_drained", exp_q.size(), 0);
  endtask

  task automatic run_clear(input bit also_plot, input int abort_at);
    int cnt;
    check("clear_model_first", {14'd0, exp_q[0]}, 32'd0);
    check("clear_model_last", {14'd0, exp_q[exp_q.size()-1]}, {14'd0, 8'd159, 7'd119, 3'd0});
    tick();
    clear = 1'b1;
    plot = also_plot;
    tick();
    clear = 1'b0;
    plot = 1'b0;
    cnt = 0;
    while (cnt < 20000) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      cnt++;
      if (cnt == 1)   check("clear_entry_counter", {28'd0, counter_out}, 0);
      if (cnt == 50)  plot = 1'b1;
      if (cnt == 60)  check("clear_plot_ignored", {28'd0, counter_out}, 0);
      if (cnt == 70)  plot = 1'b0;
      if (cnt == 100) begin ld_x = 1'b1; data_in = 7'd5; end
      if (cnt == 101) ld_x = 1'b0;
      if (cnt == 200) clear = 1'b1;
      if (cnt == 201) clear = 1'b0;
      if (cnt == abort_at) begin
        abort_reset("clear_abort");
        return;
      end
    end
    check("busy_cycles", cnt, SW * SH);
    check("last_write_at_busy_fall", {31'd0, vga_plot}, 1);
    @(negedge clk);
    check("plot_fall", {31'd0, vga_plot}, 0);
    repeat (3) tick();
    check("clear_drained", exp_q.size(), 0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {8'd0, counter_out, vga_x, vga_y, vga_colour, vga_plot, busy}, 32'd0);
    resetn = 1'b1;

    // Basic block at (10,20), colour 5
    load_xyc(10, 20, 5, 1'b1);
    push_block(10, 20, 5);
    check("model_first_px", {14'd0, exp_q[0]}, {14'd0, 8'd10, 7'd20, 3'd5});
    check("model_fifth_px", {14'd0, exp_q[4]}, {14'd0, 8'd10, 7'd21, 3'd5});
    check("model_last_px", {14'd0, exp_q[15]}, {14'd0, 8'd13, 7'd23, 3'd5});
    run_burst(-1);

    // Bottom-edge block: rows 118,119 visible, rows 120,121 clipped
    load_xyc(127, 118, 2, 1'b1);
    push_block(127, 118, 2);
    check("model_clip_count", exp_q.size(), 8);
    run_burst(-1);

    // Full clear sweep, with plot / clear / ld_x pokes during it
    push_clear();
    run_clear(1'b0, -1);

    // Clear and plot together: clear wins
    push_clear();
    run_clear(1'b1, -1);

    // Reset at counter_out = 7 mid-burst
    load_xyc(30, 40, 6, 1'b1);
    push_block(30, 40, 6);
    run_burst(7);

    // Reset mid-clear
    push_clear();
    run_clear(1'b0, 500);

    // ld_x=5 lands during the sweep; the next block anchors there
    push_clear();
    run_clear(1'b0, -1);
    load_xyc(0, 60, 1, 1'b0);
    push_block(5, 60, 1);
    check("model_anchor_x5", {14'd0, exp_q[0]}, {14'd0, 8'd5, 7'd60, 3'd1});
    run_burst(-1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
